// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: function codes
// and FSM state encoding. When MIPS_MULDIV_FAST_MUL_EN is defined the
// multiply state does not exist because multiplies complete at issue.
package mips_cpu_muldiv_pkg;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; a zero divisor always "fits", giving all-ones quotient bits.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    diff_s    = shifted_s - {1'b0, divisor_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      q_o   = 1'b1;
      rem_o = diff_s[WIDTH-1:0];
    end else begin
      q_o   = 1'b0;
      rem_o = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO. Signed operations work on
// operand magnitudes and apply the sign correction in the FIX state.
// prod_q doubles as the multiply accumulator {upper, multiplier} and as the
// divide working register {remainder, dividend/quotient}.
// Optional: MIPS_MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ALU_control,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div0_q, div0_d;
  logic               is_mul_q, is_mul_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_signed_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic               step_q_s;
  logic [WIDTH:0]     mul_sum_s;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a_s, ext_b_s, fast_prod_s;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (prod_q[2*WIDTH-1:WIDTH]),
    .bit_i     (prod_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Operand decode: signedness and magnitudes used when an op is latched.
  always_comb begin
    is_signed_s = (ALU_control == FN_MULT) || (ALU_control == FN_DIV);
    a_neg_s     = is_signed_s & rs_content[WIDTH-1];
    b_neg_s     = is_signed_s & rt_content[WIDTH-1];
    a_mag_s     = a_neg_s ? ({WIDTH{1'b0}} - rs_content) : rs_content;
    b_mag_s     = b_neg_s ? ({WIDTH{1'b0}} - rt_content) : rt_content;
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`ifdef MIPS_MULDIV_FAST_MUL_EN
    ext_a_s     = {{WIDTH{a_neg_s}}, rs_content};
    ext_b_s     = {{WIDTH{b_neg_s}}, rt_content};
    fast_prod_s = ext_a_s * ext_b_s;
`endif
  end

  // Next-state logic: issue, per-bit iteration and final sign correction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    is_mul_d = is_mul_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (ALU_control)
            FN_MULT, FN_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod_s;
              done_d       = 1'b1;
`else
              state_d  = ST_MUL;
              busy_d   = 1'b1;
              cnt_d    = {CW{1'b0}};
              opnd_d   = a_mag_s;
              prod_d   = {{WIDTH{1'b0}}, b_mag_s};
              neg_lo_d = a_neg_s ^ b_neg_s;
              neg_hi_d = 1'b0;
              div0_d   = 1'b0;
              is_mul_d = 1'b1;
`endif
            end
            FN_DIV, FN_DIVU: begin
              state_d  = ST_DIV;
              busy_d   = 1'b1;
              cnt_d    = {CW{1'b0}};
              opnd_d   = b_mag_s;
              prod_d   = {{WIDTH{1'b0}}, a_mag_s};
              neg_lo_d = a_neg_s ^ b_neg_s;
              neg_hi_d = a_neg_s;
              div0_d   = (rt_content == {WIDTH{1'b0}});
              is_mul_d = 1'b0;
            end
            FN_MTHI: hi_d = rs_content;
            FN_MTLO: lo_d = rs_content;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifndef MIPS_MULDIV_FAST_MUL_EN
      ST_MUL: begin
        prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_MUL;
        end
      end
`endif
      ST_DIV: begin
        prod_d = {step_rem_s, prod_q[WIDTH-2:0], step_q_s};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        if (is_mul_q) begin
          {hi_d, lo_d} = neg_lo_q ? ({(2*WIDTH){1'b0}} - prod_q) : prod_q;
        end else begin
          lo_d = div0_q   ? {WIDTH{1'b1}} :
                 neg_lo_q ? ({WIDTH{1'b0}} - prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
          hi_d = neg_hi_q ? ({WIDTH{1'b0}} - prod_q[2*WIDTH-1:WIDTH])
                          : prod_q[2*WIDTH-1:WIDTH];
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset aborting any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      is_mul_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      is_mul_q <= is_mul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv (WIDTH=32). Cycle numbering: cycle 1 is
// the cycle right after the acceptance edge.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  ALU_control = 6'h00;
  logic [31:0] rs_content = 32'h0;
  logic [31:0] rt_content = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
  localparam int MUL_DONE = 1;
`else
  localparam int MUL_BUSY = 33;
  localparam int MUL_DONE = 34;
`endif
  localparam int DIV_BUSY = 33;
  localparam int DIV_DONE = 34;

  always #5 clk = ~clk;

  mips_cpu_muldiv dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALU_control (ALU_control),
    .rs_content  (rs_content),
    .rt_content  (rt_content),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  // Present one start request for exactly one rising edge; returns #1 after it.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALU_control = op; rs_content = a; rt_content = b;
    @(posedge clk); #1;
    start = 1'b0; ALU_control = 6'h00;
  endtask

  // Step cycles until done, counting busy cycles; bounded to 100 cycles.
  task automatic run_wait(input int first_cyc, output int busy_cnt, output int done_cyc);
    int cyc;
    cyc = first_cyc; busy_cnt = 0; done_cyc = 0;
    while (cyc <= 100 && done_cyc == 0) begin
      if (busy) busy_cnt++;
      if (done) done_cyc = cyc;
      else begin @(posedge clk); #1; cyc++; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_multu();
    int bc, dc;
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_wait(1, bc, dc);
    checks++; if (bc !== MUL_BUSY) begin errors++; $display("FAIL multu_busy_cycles got %0d exp %0d", bc, MUL_BUSY); end
    checks++; if (dc !== MUL_DONE) begin errors++; $display("FAIL multu_done_cycle got %0d exp %0d", dc, MUL_DONE); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp %h", hi, 32'hFFFFFFFE); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp %h", lo, 32'h00000001); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_mult();
    int bc, dc;
    issue(6'h18, 32'hFFFFFFFD, 32'h00000005);
    run_wait(1, bc, dc);
    checks++; if (bc !== MUL_BUSY) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", bc, MUL_BUSY); end
    checks++; if (dc !== MUL_DONE) begin errors++; $display("FAIL mult_done_cycle got %0d exp %0d", dc, MUL_DONE); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp %h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp %h", lo, 32'hFFFFFFF1); end
  endtask

  task automatic test_div();
    int bc, dc;
    // hi/lo from previous mult must hold until the FIX edge
    issue(6'h1a, 32'hFFFFFFF9, 32'h00000002);
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL div_lo_hold got %h exp %h", lo, 32'hFFFFFFF1); end
    run_wait(1, bc, dc);
    checks++; if (bc !== DIV_BUSY) begin errors++; $display("FAIL div_busy_cycles got %0d exp %0d", bc, DIV_BUSY); end
    checks++; if (dc !== DIV_DONE) begin errors++; $display("FAIL div_done_cycle got %0d exp %0d", dc, DIV_DONE); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg7_2_lo got %h exp %h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg7_2_hi got %h exp %h", hi, 32'hFFFFFFFF); end
    issue(6'h1b, 32'h00000007, 32'h00000002);
    run_wait(1, bc, dc);
    checks++; if (lo !== 32'h00000003) begin errors++; $display("FAIL divu_7_2_lo got %h exp %h", lo, 32'h3); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL divu_7_2_hi got %h exp %h", hi, 32'h1); end
    issue(6'h1a, 32'h00000007, 32'hFFFFFFFE);
    run_wait(1, bc, dc);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_neg2_lo got %h exp %h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_7_neg2_hi got %h exp %h", hi, 32'h1); end
  endtask

  task automatic test_div_edge();
    int bc, dc;
    issue(6'h1b, 32'h00001234, 32'h00000000);
    run_wait(1, bc, dc);
    checks++; if (dc !== DIV_DONE) begin errors++; $display("FAIL divzero_done_cycle got %0d exp %0d", dc, DIV_DONE); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divzero_lo got %h exp %h", lo, 32'hFFFFFFFF); end
    checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL divzero_hi got %h exp %h", hi, 32'h00001234); end
    issue(6'h1a, 32'h80000000, 32'hFFFFFFFF);
    run_wait(1, bc, dc);
    checks++; if (dc !== DIV_DONE) begin errors++; $display("FAIL ovf_done_cycle got %0d exp %0d", dc, DIV_DONE); end
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h exp %h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL ovf_hi got %h exp %h", hi, 32'h0); end
  endtask

  task automatic test_hazard();
    int bc, dc, dcount;
    // divu 100/7 = 14 r 2; mthi and mult issued while busy must be ignored
    issue(6'h1b, 32'd100, 32'd7);
    issue(6'h11, 32'h0000AAAA, 32'h0);
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL busy_mthi_ignored got %h exp %h", hi, 32'h0); end
    issue(6'h18, 32'd2, 32'd3);
    run_wait(3, bc, dc);
    checks++; if (dc !== DIV_DONE) begin errors++; $display("FAIL busy_done_cycle got %0d exp %0d", dc, DIV_DONE); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_divu_lo got %h exp %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL busy_divu_hi got %h exp %h", hi, 32'd2); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got %b exp 0", busy); end
    // reset during busy cycle 10
    issue(6'h1b, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo got %h exp %h", lo, 32'h0); end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", dcount); end
  endtask

  task automatic test_sequence();
    int bc, dc;
    issue(6'h13, 32'h00000055, 32'h0);
    checks++; if (lo !== 32'h00000055) begin errors++; $display("FAIL mtlo_lo got %h exp %h", lo, 32'h55); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mtlo_hi got %h exp %h", hi, 32'h0); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy_next got %b exp 0", busy); end
    issue(6'h1b, 32'd7, 32'd2);
    run_wait(1, bc, dc);
    checks++; if (dc !== DIV_DONE) begin errors++; $display("FAIL b2b_first_done got %0d exp %0d", dc, DIV_DONE); end
    // issued in the done cycle
    issue(6'h19, 32'd2, 32'd3);
    run_wait(1, bc, dc);
    checks++; if (bc !== MUL_BUSY) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp %0d", bc, MUL_BUSY); end
    checks++; if (dc !== MUL_DONE) begin errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", dc, MUL_DONE); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo got %h exp %h", lo, 32'd6); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_edge();
    test_hazard();
    test_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
